fp_add_arbiter: RTL and testbench
=================================

# fp_add_arbiter

Shares one combinational bfloat16 adder (`fp_add`, driven through an `op_intf` instance) among `NUM_REQ` requesters. A round-robin grant selects one request per cycle. The block registers the winning operands, then registers the adder result, and returns it with the requester's index over a valid/ready response port. It sits between the vector/accumulate front ends and the adder so that the adder's long combinational path is bounded by flops on both sides.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `EXP_WIDTH`, 8: exponent width passed to `fp_add`.
- `FRAC_WIDTH`, 7: fraction width passed to `fp_add`; `W = 1+EXP_WIDTH+FRAC_WIDTH` (16).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set.
- `req_op1`  in  NUM_REQ*W  operand 1, requester i at `[i*W +: W]`, packed {sign, exp, frac}.
- `req_op2`  in  NUM_REQ*W  operand 2, same packing.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  W  sum, packed {op3_sign, op3_exp, op3_frac}.
- `rsp_id`  out  $clog2(NUM_REQ)  index of the requester that issued the sum.
- `busy`  out  1  either pipeline stage holds a valid entry.

## Operation
- Two register stages:
  - **A (operands):** `a_valid`, `a_op1`, `a_op2`, `a_id`. Feeds `op_intf` unregistered.
  - **B (result):** `b_valid`, `b_data`, `b_id`. Captures the adder output. `rsp_*` are driven directly from B.
- Stall rules:
  - `b_advance = !b_valid | rsp_ready`.
  - `a_advance = !a_valid | b_advance`.
  - B loads `a_valid`/data when `b_advance`.
  - A loads the granted request when `a_advance`. If `a_advance` and no request is granted, `a_valid` clears.
- Arbitration:
  - Round-robin pointer `rr_ptr` (index of the highest-priority requester).
  - The grant is the first set `req_valid` bit at or after `rr_ptr`, searching modulo NUM_REQ.
  - `req_ready = grant_onehot & {NUM_REQ{a_advance}}` (combinational).
  - On a handshake, `rr_ptr <= granted_id + 1`, wrapping at NUM_REQ-1 → 0. Otherwise `rr_ptr` holds.
- Fairness: a continuously valid requester is granted within NUM_REQ handshakes.
- Requesters must not make `req_valid` depend on `req_ready`. Once `req_valid` is asserted, it and the operands are held until the handshake.
- Arithmetic:
  - Operands are split into sign/exp/frac onto `op_intf`.
  - The result is taken verbatim from `fp_add`; the block does no rounding, normalization or special-value handling.
  - Zero, Inf and NaN operands pass through with whatever result `fp_add` produces.
- Reset: `a_valid=0`, `b_valid=0`, `rr_ptr=0`.
  - Reset asserted mid-operation drops both in-flight entries without emitting them.
  - The data/id registers need no reset.

## Timing
- Reset values:
  - `rsp_valid=0`, `busy=0`, `rsp_data=0`, `rsp_id=0`.
  - `req_ready=0` while `rst` is high; during reset `a_advance` is forced to 0.
- Latency: a handshake in cycle N gives `rsp_valid=1` in cycle N+2 when `rsp_ready` was high (or B empty) in N+1.
- Throughput: one result per cycle with `rsp_ready` held high.
- Full pipe with `rsp_ready=0`: B holds, A holds, all `req_ready=0`, `rr_ptr` frozen.
- Simultaneous `rsp_ready=1` with A and B both full: B takes A, and A takes a new grant in the same cycle. No bubble and no loss.
- `rsp_data`/`rsp_id` are stable while `rsp_valid && !rsp_ready`.
- `busy = a_valid | b_valid`.

## Test plan
- **Single request:** after reset, req0 {op1=0x3F80 (1.0), op2=0x4000 (2.0)} for 1 cycle with `rsp_ready=1`.
  - `req_ready[0]=1` in cycle N.
  - `rsp_valid=1` in N+2 with `rsp_data=0x4040` (3.0), `rsp_id=0`.
  - `busy` falls at N+3.
- **Round robin:** all 4 requesters valid continuously, each op1=op2=0x3F80.
  - Grants go 0,1,2,3,0,…, one per cycle.
  - Responses are 0x4000 with `rsp_id` 0,1,2,3 in that order.
- **Pointer wrap:** `rr_ptr=3` after a grant to req2; req0 and req3 valid.
  - req3 is granted, then req0.
  - `rr_ptr` goes 3 → 0 → 1.
- **Backpressure:** stream of 1.5+1.5 (0x3FC0) from req1; hold `rsp_ready=0` for 5 cycles.
  - `rsp_data=0x4040` is held stable.
  - `req_ready[1]=0` once A and B are full.
  - Releasing `rsp_ready` drains both entries in consecutive cycles, then new grants resume the same cycle.
- **Reset mid-flight:** A and B full; assert `rst` for 1 cycle.
  - `rsp_valid=0` and `busy=0` the next cycle.
  - The dropped results never appear.
  - The next grant goes to the lowest valid index.
- **Idle bubbles:** req2 pulses valid every third cycle.
  - `rsp_valid` pulses for exactly one cycle, 2 cycles after each handshake.
  - No duplicate responses.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that shares one combinational bfloat16 adder among NUM_REQ requesters,
// with an operand register in front of the adder and a result register behind it.

interface op_intf #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
);
  logic                  op1_sign;
  logic [EXP_WIDTH-1:0]  op1_exp;
  logic [FRAC_WIDTH-1:0] op1_frac;
  logic                  op2_sign;
  logic [EXP_WIDTH-1:0]  op2_exp;
  logic [FRAC_WIDTH-1:0] op2_frac;
  logic                  op3_sign;
  logic [EXP_WIDTH-1:0]  op3_exp;
  logic [FRAC_WIDTH-1:0] op3_frac;

  modport adder  (input  op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
                  output op3_sign, op3_exp, op3_frac);
  modport client (output op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
                  input  op3_sign, op3_exp, op3_frac);
endinterface

// Combinational float adder: truncating, subnormals flushed to zero.
module fp_add #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
) (
  op_intf.adder io
);
  localparam int E = EXP_WIDTH;
  localparam int F = FRAC_WIDTH;
  localparam int M = F + 4;  // hidden bit + fraction + three guard bits

  logic          op1_smaller;
  logic          big_sign;
  logic          small_sign;
  logic [E-1:0]  big_exp;
  logic [E-1:0]  small_exp;
  logic [F-1:0]  big_frac;
  logic [F-1:0]  small_frac;
  logic [M-1:0]  big_mant;
  logic [M-1:0]  small_mant;
  logic [M-1:0]  small_al;
  logic [E-1:0]  exp_diff;
  logic [M:0]    mag;
  logic [E+1:0]  exp_r;
  logic          is_zero;

  always_comb begin
    op1_smaller = {io.op1_exp, io.op1_frac} < {io.op2_exp, io.op2_frac};
    if (op1_smaller) begin
      big_sign   = io.op2_sign;
      big_exp    = io.op2_exp;
      big_frac   = io.op2_frac;
      small_sign = io.op1_sign;
      small_exp  = io.op1_exp;
      small_frac = io.op1_frac;
    end else begin
      big_sign   = io.op1_sign;
      big_exp    = io.op1_exp;
      big_frac   = io.op1_frac;
      small_sign = io.op2_sign;
      small_exp  = io.op2_exp;
      small_frac = io.op2_frac;
    end

    big_mant   = {|big_exp, big_frac, 3'b000};
    small_mant = {|small_exp, small_frac, 3'b000};
    exp_diff   = big_exp - small_exp;
    small_al   = (exp_diff >= E'(M)) ? '0 : (small_mant >> exp_diff);

    if (big_sign == small_sign) begin
      mag = {1'b0, big_mant} + {1'b0, small_al};
    end else begin
      mag = {1'b0, big_mant} - {1'b0, small_al};
    end
    is_zero = (mag == '0);

    exp_r = {2'b00, big_exp};
    if (mag[M]) begin
      mag   = mag >> 1;
      exp_r = exp_r + (E+2)'(1);
    end else begin
      // Cancellation: shift left until the hidden bit is back at M-1.
      for (int i = 0; i < M; i++) begin
        if (!mag[M-1] && !is_zero) begin
          mag   = mag << 1;
          exp_r = exp_r - (E+2)'(1);
        end
      end
    end

    io.op3_sign = big_sign;
    io.op3_exp  = exp_r[E-1:0];
    io.op3_frac = mag[M-2 -: F];

    if (is_zero) begin
      io.op3_sign = big_sign & small_sign;
      io.op3_exp  = '0;
      io.op3_frac = '0;
    end else if (exp_r[E+1] || exp_r == '0) begin
      io.op3_exp  = '0;
      io.op3_frac = '0;
    end else if (exp_r >= {2'b00, {E{1'b1}}}) begin
      io.op3_exp  = '1;
      io.op3_frac = '0;
    end

    if (big_exp == '1) begin
      if (small_exp == '1 && big_sign != small_sign) begin
        io.op3_sign = 1'b0;
        io.op3_exp  = '1;
        io.op3_frac = {1'b1, {(F-1){1'b0}}};
      end else begin
        io.op3_sign = big_sign;
        io.op3_exp  = big_exp;
        io.op3_frac = big_frac;
      end
    end
  end
endmodule

module fp_add_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  EXP_WIDTH  = 8,
  parameter int  FRAC_WIDTH = 7,
  localparam int W          = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_op1,
  input  logic [NUM_REQ*W-1:0] req_op2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);
  logic [W-1:0]       op1_arr [NUM_REQ];
  logic [W-1:0]       op2_arr [NUM_REQ];

  logic               a_valid_reg;
  logic [W-1:0]       a_op1_reg;
  logic [W-1:0]       a_op2_reg;
  logic [ID_W-1:0]    a_id_reg;
  logic               b_valid_reg;
  logic [W-1:0]       b_data_reg;
  logic [ID_W-1:0]    b_id_reg;
  logic [ID_W-1:0]    rr_ptr_reg;
  logic [ID_W-1:0]    rr_ptr_next;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               a_advance;
  logic               b_advance;
  logic               handshake;
  logic [W-1:0]       sum;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op1_arr[gi] = req_op1[gi*W +: W];
      assign op2_arr[gi] = req_op2[gi*W +: W];
    end
  endgenerate

  // First valid requester at or after rr_ptr, searching modulo NUM_REQ.
  always_comb begin : p_grant
    int               idx;
    logic [ID_W-1:0]  idx_w;
    logic [NUM_REQ-1:0] shifted;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_w       = '0;
    shifted     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w   = ID_W'(idx);
      shifted = req_valid >> idx_w;
      if (!grant_found && shifted[0]) begin
        grant_found = 1'b1;
        grant_id    = idx_w;
      end
    end
  end

  assign grant_onehot = grant_found ? (NUM_REQ'(1) << grant_id) : '0;
  assign b_advance    = !b_valid_reg || rsp_ready;
  assign a_advance    = !rst && (!a_valid_reg || b_advance);
  assign handshake    = a_advance && grant_found;
  assign req_ready    = grant_onehot & {NUM_REQ{a_advance}};
  assign rr_ptr_next  = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

  op_intf #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) op_if ();

  assign op_if.op1_sign = a_op1_reg[W-1];
  assign op_if.op1_exp  = a_op1_reg[W-2 -: EXP_WIDTH];
  assign op_if.op1_frac = a_op1_reg[FRAC_WIDTH-1:0];
  assign op_if.op2_sign = a_op2_reg[W-1];
  assign op_if.op2_exp  = a_op2_reg[W-2 -: EXP_WIDTH];
  assign op_if.op2_frac = a_op2_reg[FRAC_WIDTH-1:0];
  assign sum            = {op_if.op3_sign, op_if.op3_exp, op_if.op3_frac};

  fp_add #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_fp_add (
    .io (op_if.adder)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_reg <= 1'b0;
      b_valid_reg <= 1'b0;
      rr_ptr_reg  <= '0;
      b_data_reg  <= '0;
      b_id_reg    <= '0;
    end else begin
      if (b_advance) begin
        b_valid_reg <= a_valid_reg;
        if (a_valid_reg) begin
          b_data_reg <= sum;
          b_id_reg   <= a_id_reg;
        end
      end
      if (a_advance) begin
        a_valid_reg <= grant_found;
      end
      if (handshake) begin
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  // Operand registers carry no reset; a_valid_reg qualifies them.
  always_ff @(posedge clk) begin
    if (handshake) begin
      a_op1_reg <= op1_arr[grant_id];
      a_op2_reg <= op2_arr[grant_id];
      a_id_reg  <= grant_id;
    end
  end

  assign rsp_valid = b_valid_reg;
  assign rsp_data  = b_data_reg;
  assign rsp_id    = b_id_reg;
  assign busy      = a_valid_reg | b_valid_reg;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: reset, single op, round robin, wrap, backpressure,
// reset mid-flight and isolated pulses.
module tb_fp_add_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_op1;
  logic [63:0] req_op2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  logic [15:0] op1_t [4];
  logic [15:0] op2_t [4];
  int          n_cmp = 0;
  int          n_err = 0;

  // Pointer-wrap table: valid, expected ready, expected rsp_valid, expected rsp_id.
  logic [3:0]  w_valid [8] = '{4'b0100, 4'b1001, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0]  w_ready [8] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
  logic        w_rspv  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0]  w_id    [8] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0};

  // Idle-bubble pulses: -2+1=-1, 3+(-3)=0, 1.5+1=2.5.
  logic [15:0] p_op1 [3] = '{16'h3F80, 16'h4040, 16'h3FC0};
  logic [15:0] p_op2 [3] = '{16'hC000, 16'hC040, 16'h3F80};
  logic [15:0] p_sum [3] = '{16'hBF80, 16'h0000, 16'h4020};

  assign req_op1 = {op1_t[3], op1_t[2], op1_t[1], op1_t[0]};
  assign req_op2 = {op2_t[3], op2_t[2], op2_t[1], op2_t[0]};

  fp_add_arbiter #(.NUM_REQ(4), .EXP_WIDTH(8), .FRAC_WIDTH(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] i, input logic [15:0] a, input logic [15:0] b);
    op1_t[i] = a;
    op2_t[i] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op1_t[i] = 16'h0000;
      op2_t[i] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state; req_ready must stay low while rst is high even with a request pending.
    set_op(2'd0, 16'h3F80, 16'h4000);
    req_valid = 4'b0001;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_rsp_id",    32'(rsp_id),    32'h0);

    // Single request 1.0 + 2.0
    step(); rst = 1'b0; #1;
    chk("single_ready_n", 32'(req_ready), 32'h1);
    step(); req_valid = 4'b0000; #1;
    chk("single_busy_n1", 32'(busy),      32'h1);
    chk("single_rspv_n1", 32'(rsp_valid), 32'h0);
    step(); #1;
    chk("single_rspv_n2", 32'(rsp_valid), 32'h1);
    chk("single_data_n2", 32'(rsp_data),  32'h4040);
    chk("single_id_n2",   32'(rsp_id),    32'h0);
    step(); #1;
    chk("single_busy_n3", 32'(busy),      32'h0);
    chk("single_rspv_n3", 32'(rsp_valid), 32'h0);

    // Round robin with all four continuously valid, pointer restarted by reset
    step(); rst = 1'b1; #1;
    step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op1_t[i] = 16'h3F80;
      op2_t[i] = 16'h3F80;
    end
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        step(); #1;
      end
      chk("rr_ready", 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2) begin
        chk("rr_rspv", 32'(rsp_valid), 32'h1);
        chk("rr_id",   32'(rsp_id),    32'((k - 2) % 4));
        chk("rr_data", 32'(rsp_data),  32'h4000);
      end
    end
    step(); req_valid = 4'b0000; #1;
    chk("rr_drain_id6", 32'(rsp_id), 32'h2);
    step(); #1;
    chk("rr_drain_id7", 32'(rsp_id), 32'h3);
    chk("rr_drain_v7",  32'(rsp_valid), 32'h1);
    step(); #1;
    chk("rr_drain_empty", 32'(rsp_valid), 32'h0);

    // Pointer wrap: grant req2 (ptr->3), then req3 over req0, then req0 (ptr->1)
    for (int c = 0; c < 8; c++) begin
      step();
      req_valid = w_valid[c];
      #1;
      chk("wrap_ready", 32'(req_ready), 32'(w_ready[c]));
      chk("wrap_rspv",  32'(rsp_valid), 32'(w_rspv[c]));
      if (w_rspv[c]) begin
        chk("wrap_id", 32'(rsp_id), 32'(w_id[c]));
      end
    end

    // Backpressure on a 1.5+1.5 stream from req1
    set_op(2'd1, 16'h3FC0, 16'h3FC0);
    step(); req_valid = 4'b0010; rsp_ready = 1'b1; #1;
    chk("bp_ready_p0", 32'(req_ready), 32'h2);
    step(); rsp_ready = 1'b0; #1;
    chk("bp_ready_p1", 32'(req_ready), 32'h2);
    for (int p = 2; p < 6; p++) begin
      step(); #1;
      chk("bp_ready_full", 32'(req_ready), 32'h0);
      chk("bp_rspv_hold",  32'(rsp_valid), 32'h1);
      chk("bp_data_hold",  32'(rsp_data),  32'h4040);
      chk("bp_id_hold",    32'(rsp_id),    32'h1);
    end
    step(); rsp_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(req_ready), 32'h2);
    chk("bp_release_rspv",  32'(rsp_valid), 32'h1);
    step(); req_valid = 4'b0000; #1;
    chk("bp_drain2_rspv", 32'(rsp_valid), 32'h1);
    chk("bp_drain2_data", 32'(rsp_data),  32'h4040);
    step(); #1;
    chk("bp_drain3_rspv", 32'(rsp_valid), 32'h1);
    step(); #1;
    chk("bp_empty_rspv", 32'(rsp_valid), 32'h0);
    chk("bp_empty_busy", 32'(busy),      32'h0);

    // Reset mid-flight: fill A and B with 2+2 from req3, then reset
    set_op(2'd3, 16'h4000, 16'h4000);
    step(); req_valid = 4'b1000; rsp_ready = 1'b0; #1;
    chk("rmf_ready_r0", 32'(req_ready), 32'h8);
    step(); #1;
    chk("rmf_ready_r1", 32'(req_ready), 32'h8);
    step(); rst = 1'b1; #1;
    chk("rmf_ready_rst", 32'(req_ready), 32'h0);
    chk("rmf_busy_full", 32'(busy),      32'h1);
    step();
    rst = 1'b0;
    set_op(2'd1, 16'h3F80, 16'h3F80);
    set_op(2'd3, 16'h3F80, 16'h4000);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    chk("rmf_rspv_after", 32'(rsp_valid), 32'h0);
    chk("rmf_busy_after", 32'(busy),      32'h0);
    chk("rmf_lowest",     32'(req_ready), 32'h2);
    step(); req_valid = 4'b1000; #1;
    chk("rmf_ready_r4", 32'(req_ready), 32'h8);
    chk("rmf_rspv_r4",  32'(rsp_valid), 32'h0);
    step(); req_valid = 4'b0000; #1;
    chk("rmf_rspv_r5", 32'(rsp_valid), 32'h1);
    chk("rmf_id_r5",   32'(rsp_id),    32'h1);
    chk("rmf_data_r5", 32'(rsp_data),  32'h4000);
    step(); #1;
    chk("rmf_rspv_r6", 32'(rsp_valid), 32'h1);
    chk("rmf_id_r6",   32'(rsp_id),    32'h3);
    chk("rmf_data_r6", 32'(rsp_data),  32'h4040);
    step(); #1;
    chk("rmf_rspv_r7", 32'(rsp_valid), 32'h0);

    // Idle bubbles: req2 valid every third cycle
    for (int c = 0; c < 11; c++) begin
      step();
      if (c % 3 == 0 && c < 9) begin
        set_op(2'd2, p_op1[c / 3], p_op2[c / 3]);
        req_valid = 4'b0100;
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      chk("idle_ready", 32'(req_ready), 32'(req_valid));
      if (c >= 2 && (c - 2) % 3 == 0 && c - 2 < 9) begin
        chk("idle_rspv", 32'(rsp_valid), 32'h1);
        chk("idle_id",   32'(rsp_id),    32'h2);
        chk("idle_data", 32'(rsp_data),  32'(p_sum[(c - 2) / 3]));
      end else begin
        chk("idle_quiet", 32'(rsp_valid), 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
